inst_mem_responder: RTL and testbench

- Memory-side responder for the instruction fetch interface: it serves fetch requests (instEn/instAddr) that missed in the instruction cache.
- Reads four bytes from the byte-wide synchronous RAM and assembles one little-endian 32-bit instruction.
- Returns the instruction to fetch as a one-cycle memInstOutEn/memInst pulse and writes the same word into the instruction cache.
- Sits between the fetch stage, the i-cache fill port and the RAM bus, which it shares with the data-side controller via memBusy/ifBusBusy.

---
 rtl/inst_mem_responder_if.sv | 37 +++
 rtl/inst_mem_responder.sv | 191 +++++++++++++++++++
 tb/tb_inst_mem_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_responder_if.sv
// Instruction-miss bus bundle: fetch request/response, i-cache fill port
// and the shared byte-wide RAM bus.
interface inst_mem_responder_if #(
  parameter int ADDR_W     = 32,
  parameter int RAM_ADDR_W = 17
);
  // Fetch side
  logic                  instEn;
  logic [ADDR_W-1:0]     instAddr;
  logic                  hit;
  logic                  memInstOutEn;
  logic [31:0]           memInst;
  // I-cache fill port
  logic                  cacheWrEn;
  logic [ADDR_W-1:0]     cacheWrAddr;
  logic [31:0]           cacheWrInst;
  // RAM bus, shared with the data-side controller
  logic                  memBusy;
  logic [7:0]            ram_din;
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic                  ram_rw;
  logic                  ifBusBusy;

  // The responder itself
  modport slave (
    input  instEn, instAddr, hit, memBusy, ram_din,
    output memInstOutEn, memInst, cacheWrEn, cacheWrAddr, cacheWrInst,
           ram_addr, ram_rw, ifBusBusy
  );

  // Fetch stage / RAM / arbiter side
  modport master (
    output instEn, instAddr, hit, memBusy, ram_din,
    input  memInstOutEn, memInst, cacheWrEn, cacheWrAddr, cacheWrInst,
           ram_addr, ram_rw, ifBusBusy
  );
endinterface

// File: rtl/inst_mem_responder.sv
// Instruction-miss responder: reads four bytes from the byte-wide RAM,
// assembles a little-endian word, returns it to fetch as a one-cycle pulse
// and fills the i-cache with the same word.
module inst_mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_mem_responder_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  // issue counts addresses already presented (1..4); rcv indexes the byte
  // expected on ram_din at this edge (0..3).
  logic [2:0]            issue_q, issue_d;
  logic [1:0]            rcv_q, rcv_d;
  // The RAM has one cycle of read latency, so the first edge in READ only
  // arms capture; bytes are taken from the following edge onward.
  logic                  armed_q, armed_d;
  logic [7:0]            byte_q [3];
  logic [7:0]            byte_d [3];
  logic                  capture_en;

  logic [RAM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic                  if_bus_busy_q, if_bus_busy_d;
  logic                  out_en_q, out_en_d;
  logic [31:0]           mem_inst_q, mem_inst_d;
  logic                  cache_wr_en_q, cache_wr_en_d;
  logic [ADDR_W-1:0]     cache_wr_addr_q, cache_wr_addr_d;
  logic [31:0]           cache_wr_inst_q, cache_wr_inst_d;
  logic [31:0]           word;

  // Bytes 0..2 are parked in registers; byte 3 is used straight off ram_din.
  assign capture_en = (state_q == S_READ) && armed_q;
  assign word       = {bus.ram_din, byte_q[2], byte_q[1], byte_q[0]};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_byte
      localparam logic [1:0] IDX = 2'(gi);

      // Capture this lane when the receive index reaches it.
      always_comb begin
        byte_d[gi] = byte_q[gi];
        if (capture_en && (rcv_q == IDX)) begin
          byte_d[gi] = bus.ram_din;
        end
      end

      // Byte lane register.
      always_ff @(posedge clk) begin
        if (rst) begin
          byte_q[gi] <= 8'h00;
        end else begin
          byte_q[gi] <= byte_d[gi];
        end
      end
    end
  endgenerate

  // Next-state and registered-output logic for the fetch-miss sequence.
  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    base_d          = base_q;
    issue_d         = issue_q;
    rcv_d           = rcv_q;
    armed_d         = armed_q;
    ram_addr_d      = ram_addr_q;
    if_bus_busy_d   = if_bus_busy_q;
    out_en_d        = 1'b0;
    mem_inst_d      = mem_inst_q;
    cache_wr_en_d   = 1'b0;
    cache_wr_addr_d = cache_wr_addr_q;
    cache_wr_inst_d = cache_wr_inst_q;

    unique case (state_q)
      // IDLE and DONE both accept a new miss; DONE otherwise just drops
      // the one-cycle pulse (via the defaults above) and goes idle.
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.instEn && !bus.hit) begin
          base_d = bus.instAddr;
          if (bus.memBusy) begin
            pending_d = 1'b1;
            state_d   = S_WAIT;
          end else begin
            ram_addr_d    = bus.instAddr[RAM_ADDR_W-1:0];
            issue_d       = 3'd1;
            rcv_d         = 2'd0;
            armed_d       = 1'b0;
            if_bus_busy_d = 1'b1;
            state_d       = S_READ;
          end
        end
      end

      // Data side owns the bus; start reading as soon as it lets go.
      S_WAIT: begin
        if (!bus.memBusy) begin
          ram_addr_d    = base_q[RAM_ADDR_W-1:0];
          pending_d     = 1'b0;
          issue_d       = 3'd1;
          rcv_d         = 2'd0;
          armed_d       = 1'b0;
          if_bus_busy_d = 1'b1;
          state_d       = S_READ;
        end
      end

      // Once reading, memBusy is ignored: the four-byte burst completes.
      S_READ: begin
        if (issue_q < 3'd4) begin
          // Natural RAM_ADDR_W-bit wrap across the top of RAM.
          ram_addr_d = ram_addr_q + 1'b1;
          issue_d    = issue_q + 3'd1;
        end
        if (!armed_q) begin
          armed_d = 1'b1;
        end else begin
          rcv_d = rcv_q + 2'd1;
          if (rcv_q == 2'd3) begin
            mem_inst_d      = word;
            out_en_d        = 1'b1;
            cache_wr_en_d   = 1'b1;
            cache_wr_addr_d = base_q;
            cache_wr_inst_d = word;
            if_bus_busy_d   = 1'b0;
            state_d         = S_DONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pending_q       <= 1'b0;
      base_q          <= '0;
      issue_q         <= 3'd0;
      rcv_q           <= 2'd0;
      armed_q         <= 1'b0;
      ram_addr_q      <= '0;
      if_bus_busy_q   <= 1'b0;
      out_en_q        <= 1'b0;
      mem_inst_q      <= 32'h0;
      cache_wr_en_q   <= 1'b0;
      cache_wr_addr_q <= '0;
      cache_wr_inst_q <= 32'h0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      base_q          <= base_d;
      issue_q         <= issue_d;
      rcv_q           <= rcv_d;
      armed_q         <= armed_d;
      ram_addr_q      <= ram_addr_d;
      if_bus_busy_q   <= if_bus_busy_d;
      out_en_q        <= out_en_d;
      mem_inst_q      <= mem_inst_d;
      cache_wr_en_q   <= cache_wr_en_d;
      cache_wr_addr_q <= cache_wr_addr_d;
      cache_wr_inst_q <= cache_wr_inst_d;
    end
  end

  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_rw       = 1'b0;
  assign bus.ifBusBusy    = if_bus_busy_q;
  assign bus.memInstOutEn = out_en_q;
  assign bus.memInst      = mem_inst_q;
  assign bus.cacheWrEn    = cache_wr_en_q;
  assign bus.cacheWrAddr  = cache_wr_addr_q;
  assign bus.cacheWrInst  = cache_wr_inst_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: byte RAM with one-cycle read latency,
// directed and randomized fetch misses checked against a word/latency model.
module tb_inst_mem_responder;

  localparam int ADDR_W     = 32;
  localparam int RAM_ADDR_W = 17;
  localparam int RAM_SIZE   = 1 << RAM_ADDR_W;
  localparam int LATENCY    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] mem [0:RAM_SIZE-1];

  inst_mem_responder_if #(.ADDR_W(ADDR_W), .RAM_ADDR_W(RAM_ADDR_W)) bus ();

  inst_mem_responder #(.ADDR_W(ADDR_W), .RAM_ADDR_W(RAM_ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: data for the address seen at an edge appears after it.
  always @(posedge clk) bus.ram_din <= mem[bus.ram_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: four bytes from consecutive addresses modulo RAM size, little-endian.
  function automatic logic [31:0] model_word(input logic [ADDR_W-1:0] a);
    int b;
    b = int'(a % RAM_SIZE);
    return {mem[(b + 3) % RAM_SIZE], mem[(b + 2) % RAM_SIZE],
            mem[(b + 1) % RAM_SIZE], mem[b]};
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_ifBusBusy"}, 64'(bus.ifBusBusy), 64'd0);
    chk({tag, "_outEn"},     64'(bus.memInstOutEn), 64'd0);
    chk({tag, "_cacheWrEn"}, 64'(bus.cacheWrEn), 64'd0);
  endtask

  // One miss: optional bus contention before start, optional memBusy noise
  // during READ. Checks address sequence, latency, word and fill port.
  task automatic run_fetch(input string tag, input logic [ADDR_W-1:0] addr,
                           input int busy_cycles, input bit perturb);
    logic [RAM_ADDR_W-1:0] prev_addr;
    logic [31:0]           exp_w;
    int                    pulses;
    int                    pulse_c;
    exp_w     = model_word(addr);
    prev_addr = bus.ram_addr;
    bus.instAddr = addr;
    bus.instEn   = 1'b1;
    bus.hit      = 1'b0;
    bus.memBusy  = (busy_cycles > 0);
    tick();
    bus.instEn = 1'b0;
    if (busy_cycles > 0) begin
      for (int i = 1; i < busy_cycles; i++) begin
        chk({tag, "_wait_addr"}, 64'(bus.ram_addr), 64'(prev_addr));
        chk({tag, "_wait_busy"}, 64'(bus.ifBusBusy), 64'd0);
        tick();
      end
      chk({tag, "_wait_addr"}, 64'(bus.ram_addr), 64'(prev_addr));
      bus.memBusy = 1'b0;
      tick();
    end
    chk({tag, "_addr0"}, 64'(bus.ram_addr), 64'(addr % RAM_SIZE));
    chk({tag, "_busy"},  64'(bus.ifBusBusy), 64'd1);
    pulses  = 0;
    pulse_c = -1;
    for (int c = 1; c <= 8; c++) begin
      bus.memBusy = perturb && (c <= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      if (c <= 3) chk($sformatf("%s_addr%0d", tag, c), 64'(bus.ram_addr),
                      64'((addr + c) % RAM_SIZE));
      if (bus.memInstOutEn) begin
        pulses++;
        pulse_c = c;
        chk({tag, "_memInst"},     64'(bus.memInst), 64'(exp_w));
        chk({tag, "_cacheWrEn"},   64'(bus.cacheWrEn), 64'd1);
        chk({tag, "_cacheWrAddr"}, 64'(bus.cacheWrAddr), 64'(addr));
        chk({tag, "_cacheWrInst"}, 64'(bus.cacheWrInst), 64'(exp_w));
        chk({tag, "_busy_done"},   64'(bus.ifBusBusy), 64'd0);
      end
      if (c == LATENCY + 1) begin
        chk({tag, "_hold_inst"}, 64'(bus.memInst), 64'(exp_w));
        chk({tag, "_hold_fill"}, 64'(bus.cacheWrInst), 64'(exp_w));
        chk({tag, "_wr_clear"},  64'(bus.cacheWrEn), 64'd0);
      end
    end
    bus.memBusy = 1'b0;
    chk({tag, "_pulses"},  64'(pulses), 64'd1);
    chk({tag, "_latency"}, 64'(pulse_c), 64'(LATENCY));
  endtask

  initial begin
    logic [ADDR_W-1:0] seq_addr [3];
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] ra;
    int idx;
    int last_c;
    int cnt;

    for (int i = 0; i < RAM_SIZE; i++) mem[i] = 8'($urandom);
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05;
    mem[32'h102] = 8'h50; mem[32'h103] = 8'h00;
    bus.instEn = 1'b0; bus.instAddr = '0; bus.hit = 1'b0; bus.memBusy = 1'b0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    chk("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
    chk("rst_ram_rw",   64'(bus.ram_rw), 64'd0);
    chk("rst_memInst",  64'(bus.memInst), 64'd0);
    chk("rst_wrAddr",   64'(bus.cacheWrAddr), 64'd0);
    chk("rst_wrInst",   64'(bus.cacheWrInst), 64'd0);
    check_quiet("rst");
    rst = 1'b0;
    tick();

    // Basic miss with a known word
    run_fetch("basic", 32'h100, 0, 1'b0);
    chk("basic_literal", 64'(bus.memInst), 64'h0050_0513);

    // Hit drops the request
    ra = bus.ram_addr;
    bus.instEn = 1'b1; bus.hit = 1'b1; bus.instAddr = 32'h200;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.memInstOutEn || bus.ifBusBusy || bus.ram_addr != ra) cnt++;
    end
    chk("hit_no_activity", 64'(cnt), 64'd0);
    bus.instEn = 1'b0; bus.hit = 1'b0;
    tick();

    // Bus contention before start, then memBusy noise during READ
    run_fetch("busy", 32'h104, 3, 1'b1);

    // Continuous instEn: three back-to-back misses, 6-cycle spacing
    seq_addr[0] = 32'h0; seq_addr[1] = 32'h4; seq_addr[2] = 32'h8;
    bus.instEn = 1'b1; bus.instAddr = seq_addr[0];
    idx = 0; last_c = -1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.memInstOutEn) begin
        if (idx < 3) begin
          chk($sformatf("b2b_word%0d", idx), 64'(bus.memInst), 64'(model_word(seq_addr[idx])));
          chk($sformatf("b2b_wrAddr%0d", idx), 64'(bus.cacheWrAddr), 64'(seq_addr[idx]));
        end
        if (idx > 0) chk($sformatf("b2b_spacing%0d", idx), 64'(c - last_c), 64'd6);
        last_c = c;
        idx++;
        if (idx < 3) bus.instAddr = seq_addr[idx];
        else bus.instEn = 1'b0;
      end
    end
    bus.instEn = 1'b0;
    chk("b2b_count", 64'(idx), 64'd3);
    tick();

    // Wrap across the top of RAM
    run_fetch("wrap", 32'h1FFFE, 0, 1'b0);

    // Reset two cycles into READ abandons the fetch
    bus.instAddr = 32'h300; bus.instEn = 1'b1;
    tick();
    bus.instEn = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("abort_ram_addr", 64'(bus.ram_addr), 64'd0);
    chk("abort_memInst",  64'(bus.memInst), 64'd0);
    chk("abort_wrAddr",   64'(bus.cacheWrAddr), 64'd0);
    check_quiet("abort");
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.memInstOutEn || bus.ifBusBusy) cnt++;
    end
    chk("abort_no_response", 64'(cnt), 64'd0);
    run_fetch("after_abort", 32'h1234, 0, 1'b0);

    // Randomized misses
    for (int t = 0; t < 12; t++) begin
      cur = 32'($urandom);
      run_fetch($sformatf("rand%0d", t), cur, int'($urandom_range(0, 3)), 1'b1);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
